// File: rtl/qos_wrr_pop_scheduler.sv
// Weighted round-robin pop scheduler: four class FIFOs feed one downstream stream, 2-cycle pop-to-output latency.
// Optional per-class grant statistics are compiled in with QOS_WRR_STATS_EN.
module qos_wrr_pop_scheduler #(
  parameter int DATA_W = 10,
  parameter int W0     = 4,
  parameter int W1     = 3,
  parameter int W2     = 2,
  parameter int W3     = 1,
  parameter int CNT_W  = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [3:0]            fifo_empty,
  input  logic                  down_almost_full,
  input  logic [4*DATA_W-1:0]   fifo_rd_data,
`ifdef QOS_WRR_STATS_EN
  input  logic                  stats_clr,
  output logic [63:0]           grant_cnt,
`endif
  output logic [3:0]            pop,
  output logic [DATA_W-1:0]     out_data,
  output logic                  out_valid,
  output logic [1:0]            out_class
);

  logic [CNT_W-1:0] wt  [4];
  logic [CNT_W-1:0] cnt [4];
  logic [3:0]       elig;
  logic [1:0]       pop_idx;
  logic             pop_any;
  logic             vld_p0;
  logic [1:0]       grant_idx_p0;

  assign wt[0] = CNT_W'(W0);
  assign wt[1] = CNT_W'(W1);
  assign wt[2] = CNT_W'(W2);
  assign wt[3] = CNT_W'(W3);

  function automatic logic [DATA_W-1:0] sel_word(input logic [4*DATA_W-1:0] words,
                                                 input logic [1:0] idx);
    sel_word = words[idx*DATA_W +: DATA_W];
  endfunction

  always_comb begin
    for (int n = 0; n < 4; n++) begin
      elig[n] = !fifo_empty[n] && (cnt[n] < wt[n]);
    end
  end

  // Strict priority inside a round: lowest eligible class wins.
  always_comb begin
    pop     = '0;
    pop_idx = '0;
    pop_any = 1'b0;
    if (!reset && !down_almost_full) begin
      for (int n = 3; n >= 0; n--) begin
        if (elig[n]) pop_idx = 2'(n);
      end
      pop_any = |elig;
      if (pop_any) pop[pop_idx] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int n = 0; n < 4; n++) cnt[n] <= '0;
      vld_p0       <= 1'b0;
      grant_idx_p0 <= '0;
      out_valid    <= 1'b0;
      out_class    <= '0;
      out_data     <= '0;
    end else begin
      // Round accounting; an idle or exhausted round restarts with one bubble.
      if (!down_almost_full) begin
        if (pop_any) begin
          cnt[pop_idx] <= cnt[pop_idx] + CNT_W'(1);
        end else begin
          for (int n = 0; n < 4; n++) cnt[n] <= '0;
        end
      end
      // Stage p0: remember which FIFO was popped.
      vld_p0       <= pop_any;
      grant_idx_p0 <= pop_idx;
      // Stage p1: FIFO read data arrives, mux and register it.
      out_valid    <= vld_p0;
      out_class    <= grant_idx_p0;
      out_data     <= sel_word(fifo_rd_data, grant_idx_p0);
    end
  end

`ifdef QOS_WRR_STATS_EN
  logic [15:0] gcnt [4];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int n = 0; n < 4; n++) gcnt[n] <= '0;
    end else begin
      for (int n = 0; n < 4; n++) begin
        if (stats_clr) gcnt[n] <= '0;
        else if (pop[n] && gcnt[n] != 16'hFFFF) gcnt[n] <= gcnt[n] + 16'd1;
      end
    end
  end

  assign grant_cnt = {gcnt[3], gcnt[2], gcnt[1], gcnt[0]};
`endif

endmodule

// File: tb/tb_qos_wrr_pop_scheduler.sv
// Directed testbench for qos_wrr_pop_scheduler with hand-computed pop sequences.
module tb_qos_wrr_pop_scheduler;
  localparam int DATA_W = 10;

  logic                clk = 1'b0;
  logic                reset;
  logic [3:0]          fifo_empty;
  logic                down_almost_full;
  logic [4*DATA_W-1:0] fifo_rd_data;
  logic [3:0]          pop;
  logic [DATA_W-1:0]   out_data;
  logic                out_valid;
  logic [1:0]          out_class;
`ifdef QOS_WRR_STATS_EN
  logic                stats_clr;
  logic [63:0]         grant_cnt;
`endif

  int checks = 0;
  int errors = 0;

  qos_wrr_pop_scheduler #(.DATA_W(DATA_W)) dut (
    .clk(clk),
    .reset(reset),
    .fifo_empty(fifo_empty),
    .down_almost_full(down_almost_full),
    .fifo_rd_data(fifo_rd_data),
`ifdef QOS_WRR_STATS_EN
    .stats_clr(stats_clr),
    .grant_cnt(grant_cnt),
`endif
    .pop(pop),
    .out_data(out_data),
    .out_valid(out_valid),
    .out_class(out_class)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drain;
    fifo_empty = 4'hF;
    down_almost_full = 1'b0;
    tick(); tick(); tick();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL drain_out_valid got %0b want 0", out_valid);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    fifo_empty = 4'h0;
    down_almost_full = 1'b0;
    #2;
    checks++;
    if (pop !== 4'h0) begin errors++; $display("FAIL reset_pop got %h want 0", pop); end
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %0b want 0", out_valid); end
    checks++;
    if (out_data !== '0) begin errors++; $display("FAIL reset_out_data got %h want 0", out_data); end
    checks++;
    if (out_class !== 2'd0) begin errors++; $display("FAIL reset_out_class got %0d want 0", out_class); end
`ifdef QOS_WRR_STATS_EN
    checks++;
    if (grant_cnt !== 64'd0) begin errors++; $display("FAIL reset_grant_cnt got %h want 0", grant_cnt); end
`endif
    fifo_empty = 4'hF;
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_wrr_full;
    int seq [22] = '{0,0,0,0,1,1,1,2,2,3,-1, 0,0,0,0,1,1,1,2,2,3,-1};
    logic [3:0] ep;
    fifo_empty = 4'h0;
    down_almost_full = 1'b0;
    for (int i = 0; i < 22; i++) begin
      #1;
      ep = (seq[i] < 0) ? 4'h0 : 4'(1 << seq[i]);
      checks++;
      if (pop !== ep) begin errors++; $display("FAIL wrr_pop[%0d] got %h want %h", i, pop, ep); end
      if (i >= 2) begin
        checks++;
        if (out_valid !== (seq[i-2] >= 0)) begin
          errors++; $display("FAIL wrr_valid[%0d] got %0b want %0b", i, out_valid, seq[i-2] >= 0);
        end
        if (seq[i-2] >= 0) begin
          checks++;
          if (out_class !== 2'(seq[i-2]) || out_data !== 10'(10'h100 + seq[i-2])) begin
            errors++; $display("FAIL wrr_out[%0d] got class %0d data %h want class %0d", i, out_class, out_data, seq[i-2]);
          end
        end
      end
      tick();
    end
    drain();
  endtask

  task automatic test_single_class2;
    int seq [8] = '{2,2,-1,2,2,-1,2,2};
    logic [3:0] ep;
    fifo_empty = 4'b1011;
    down_almost_full = 1'b0;
    for (int i = 0; i < 8; i++) begin
      #1;
      ep = (seq[i] < 0) ? 4'h0 : 4'(1 << seq[i]);
      checks++;
      if (pop !== ep) begin errors++; $display("FAIL c2_pop[%0d] got %h want %h", i, pop, ep); end
      if (i >= 2) begin
        checks++;
        if (out_valid !== (seq[i-2] >= 0) || (seq[i-2] >= 0 && out_class !== 2'd2)) begin
          errors++; $display("FAIL c2_out[%0d] got valid %0b class %0d want valid %0b class 2", i, out_valid, out_class, seq[i-2] >= 0);
        end
      end
      tick();
    end
    drain();
  endtask

  task automatic test_backpressure;
    int   seq [8] = '{0,0,-1,-1,-1,0,0,1};
    logic daf [8] = '{1'b0,1'b0,1'b1,1'b1,1'b1,1'b0,1'b0,1'b0};
    logic [3:0] ep;
    fifo_empty = 4'h0;
    for (int i = 0; i < 8; i++) begin
      down_almost_full = daf[i];
      #1;
      ep = (seq[i] < 0) ? 4'h0 : 4'(1 << seq[i]);
      checks++;
      if (pop !== ep) begin errors++; $display("FAIL bp_pop[%0d] got %h want %h", i, pop, ep); end
      if (i >= 2) begin
        checks++;
        if (out_valid !== (seq[i-2] >= 0)) begin
          errors++; $display("FAIL bp_valid[%0d] got %0b want %0b", i, out_valid, seq[i-2] >= 0);
        end
      end
      tick();
    end
    drain();
  endtask

  task automatic test_empty_refill;
    int         seq [8] = '{0,1,1,0,0,0,1,2};
    logic [3:0] emp [8] = '{4'h0,4'h1,4'h1,4'h0,4'h0,4'h0,4'h0,4'h0};
    logic [3:0] ep;
    down_almost_full = 1'b0;
    for (int i = 0; i < 8; i++) begin
      fifo_empty = emp[i];
      #1;
      ep = 4'(1 << seq[i]);
      checks++;
      if (pop !== ep) begin errors++; $display("FAIL refill_pop[%0d] got %h want %h", i, pop, ep); end
      if (i >= 2) begin
        checks++;
        if (out_valid !== 1'b1 || out_class !== 2'(seq[i-2])) begin
          errors++; $display("FAIL refill_out[%0d] got valid %0b class %0d want 1 class %0d", i, out_valid, out_class, seq[i-2]);
        end
      end
      tick();
    end
    drain();
  endtask

  task automatic test_reset_midflight;
    int seq [5] = '{0,0,0,0,1};
    logic [3:0] ep;
    fifo_empty = 4'h0;
    down_almost_full = 1'b0;
    #1;
    checks++;
    if (pop !== 4'h1) begin errors++; $display("FAIL rmid_pop0 got %h want 1", pop); end
    tick();
    tick();
    reset = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL rmid_valid_async got %0b want 0", out_valid); end
    checks++;
    if (pop !== 4'h0) begin errors++; $display("FAIL rmid_pop_in_reset got %h want 0", pop); end
    tick();
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL rmid_valid_held got %0b want 0", out_valid); end
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      ep = 4'(1 << seq[i]);
      checks++;
      if (pop !== ep) begin errors++; $display("FAIL rmid_pop[%0d] got %h want %h", i, pop, ep); end
      if (i < 2) begin
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL rmid_no_stale[%0d] got %0b want 0", i, out_valid); end
      end
      tick();
    end
    drain();
  endtask

`ifdef QOS_WRR_STATS_EN
  task automatic test_stats;
    stats_clr = 1'b1;
    tick();
    checks++;
    if (grant_cnt !== 64'd0) begin errors++; $display("FAIL stats_clr0 got %h want 0", grant_cnt); end
    stats_clr = 1'b0;
    fifo_empty = 4'h0;
    down_almost_full = 1'b0;
    for (int i = 0; i < 11; i++) tick();
    checks++;
    if (grant_cnt !== {16'd1, 16'd2, 16'd3, 16'd4}) begin
      errors++; $display("FAIL stats_round got %h want %h", grant_cnt, {16'd1, 16'd2, 16'd3, 16'd4});
    end
    stats_clr = 1'b1;
    tick();
    checks++;
    if (grant_cnt !== 64'd0) begin errors++; $display("FAIL stats_clr_wins got %h want 0", grant_cnt); end
    stats_clr = 1'b0;
    tick();
    checks++;
    if (grant_cnt !== 64'd1) begin errors++; $display("FAIL stats_inc got %h want 1", grant_cnt); end
    drain();
  endtask
`endif

  initial begin
`ifdef QOS_WRR_STATS_EN
    stats_clr = 1'b0;
`endif
    fifo_rd_data = {10'h103, 10'h102, 10'h101, 10'h100};
    test_reset();
    test_wrr_full();
    test_single_class2();
    test_backpressure();
    test_empty_refill();
    test_reset_midflight();
`ifdef QOS_WRR_STATS_EN
    test_stats();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/qos_wrr_pop_scheduler.md
Name: qos_wrr_pop_scheduler

Overview:
- Weighted round-robin pop scheduler for the four per-class FIFOs of the QoS PCIe path.
- Sits between the four class FIFOs and the single downstream FIFO.
- Drives one-hot pop to the class FIFOs, then muxes and registers the returned FIFO read data into one output stream.
- Enforces per-round weights, downstream back-pressure via almost-full, and a fixed 2-cycle pop-to-output latency.

Parameters:
- DATA_W, 10, width of one FIFO word.
- W0, 4, pops per round for class 0 (highest priority).
- W1, 3, pops per round for class 1.
- W2, 2, pops per round for class 2.
- W3, 1, pops per round for class 3. A weight of 0 disables that class.
- CNT_W, 3, width of each per-class round counter; must hold max(Wn).

Ports:
- clk  input  1  clock, all state on rising edge.
- reset  input  1  asynchronous, active-high reset.
- fifo_empty  input  4  empty flag per class FIFO; bit n = class n.
- down_almost_full  input  1  downstream FIFO almost-full.
- fifo_rd_data  input  4*DATA_W  read data; class n occupies [n*DATA_W +: DATA_W]; valid 1 cycle after pop.
- pop  output  4  one-hot (or zero) pop to class FIFOs, combinational from state and inputs.
- out_data  output  DATA_W  registered scheduled word.
- out_valid  output  1  registered; out_data is meaningful when high.
- out_class  output  2  registered class index of out_data.

Behaviour:
- Reset (async, active-high): cnt0..cnt3=0, grant_vld_q=0, grant_idx_q=0, out_valid=0, out_data=0, out_class=0. pop is 0 while reset is high.
- Eligibility: elig[n] = !fifo_empty[n] && cnt_n < Wn.
- pop: 0 when down_almost_full=1. Otherwise pop[n]=1 for the lowest n with elig[n]=1 (strict order 0>1>2>3 inside a round). At most one bit is set.
- Counter update per edge:
  - down_almost_full=1: all counters hold.
  - Else, a pop issued to class n: cnt_n increments; others hold.
  - Else, no class eligible: all counters clear to 0 (round restart). This costs exactly one bubble cycle when non-empty classes remain.
- Round restart covers both exhaustion (all non-empty classes reached weight) and idle (all FIFOs empty). An empty class forfeits its remaining slots for the current round.
- Counters never exceed Wn, so no wrap-around.
- Pipeline:
  - Cycle N: pop issued. Edge ending N captures grant_vld_q=1 and grant_idx_q=n.
  - Cycle N+1: fifo_rd_data valid. Edge ending N+1 captures out_data=fifo_rd_data[grant_idx_q], out_class=grant_idx_q, out_valid=grant_vld_q.
  - Total latency pop→out_valid: 2 cycles.
  - Back-to-back pops give back-to-back out_valid.
- down_almost_full rising does not cancel words already in flight: up to 2 more out_valid cycles follow the last pop. The downstream almost-full threshold accounts for 2 words.
- fifo_empty and down_almost_full changing in the same cycle: pop is evaluated on current values only; no registered lookahead.
- Reset asserted mid-operation clears the pipeline; in-flight words are dropped and out_valid is 0 immediately.

Optional Feature:
- Macro: QOS_WRR_STATS_EN.
- Defined:
  - Adds output grant_cnt [63:0], with class n at [16n +: 16].
  - Each 16-bit counter increments on every pop to class n and saturates at 16'hFFFF.
  - Adds input stats_clr [1]; a synchronous clear that wins over a same-cycle increment.
  - Counters are reset to 0 by reset.
- Undefined: ports and counters are absent; the scheduling datapath is identical.

Test Plan:
- All FIFOs non-empty, almost_full=0, default weights → pop sequence 1,1,1,1,2,2,2,4,4,8 then one 0 bubble, repeating; out_class follows 2 cycles later.
- Only class 2 non-empty → pop=4,4,0,4,4,0…; out_valid high 2 cycles after each pop.
- down_almost_full raised mid-round after two class-0 pops → pop=0 and counters hold; on release, class 0 gets exactly 2 more pops before class 1.
- Class 0 goes empty after 1 pop with others full → class 1 gets the next pop. Class 0 refilled mid-round → it resumes (cnt0=1<4) and preempts class 1.
- Reset asserted in the cycle after a pop → out_valid=0 with no output for the in-flight word; the first pop after reset release is class 0.
- QOS_WRR_STATS_EN with 70000 class-3 pops (W3=1) → grant_cnt[63:48]=16'hFFFF; stats_clr pulse → 0.
